u_add_1: RTL and testbench

U_ADD_1 -- requirements
Module: u_add_1

---
 rtl/u_add_pkg.sv | 11 +
 rtl/u_add_1_cell.sv | 15 +
 rtl/u_add_1.sv | 81 ++++++++
 tb/tb_u_add_1.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/u_add_pkg.sv
// Shared constants for the u_add increment family: default word length
// and the overflow-mode selectors.
package u_add_pkg;

   localparam int WL_DEFAULT   = 8;

   // Overflow behaviour when the operand is the largest positive code
   localparam int SAT_WRAP     = 0;
   localparam int SAT_SATURATE = 1;

endpackage : u_add_pkg

// File: rtl/u_add_1_cell.sv
// Single half-adder bit of the increment carry chain.
module u_add_1_cell (
   input  logic a,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Half adder: the chain's only addend besides the operand is the carry
   always_comb begin
      sum  = a ^ cin;
      cout = a & cin;
   end

endmodule : u_add_1_cell

// File: rtl/u_add_1.sv
// Signed increment by one: OUT = IN + 1, with optional saturation at the
// largest positive code and an optional single output register.
module u_add_1
   import u_add_pkg::*;
#(
   parameter int WL  = WL_DEFAULT,
   parameter int SAT = SAT_WRAP,
   parameter int LAT = 1
) (
   input  logic                 W_clk,
   input  logic                 W_rst,
   input  logic signed [WL-1:0] IN,
   output logic signed [WL-1:0] OUT,
   output logic                 OVF
);

   // Largest positive two's-complement value: 0111...1
   localparam logic [WL-1:0] MAX_POS = {1'b0, {(WL-1){1'b1}}};

   logic [WL:0]   carry;
   logic [WL-1:0] sum_bits;
   logic [WL-1:0] res_comb;
   logic          ovf_comb;

   // The chain's carry-out is intentionally dropped (modular arithmetic)
   logic          unused_carry_out;
   assign unused_carry_out = carry[WL];

   // Carry-in of one turns the half-adder chain into an incrementer
   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < WL; gi++) begin : g_chain
         u_add_1_cell u_cell (
            .a    (IN[gi]),
            .cin  (carry[gi]),
            .sum  (sum_bits[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   // Overflow detect and saturation select on the raw chain result
   always_comb begin
      ovf_comb = (IN == MAX_POS);
      res_comb = sum_bits;
      if ((SAT != SAT_WRAP) && ovf_comb) begin
         res_comb = MAX_POS;
      end
   end

   generate
      if (LAT != 0) begin : g_reg
         logic [WL-1:0] out_reg;
         logic          ovf_reg;

         // One-cycle output register, cleared asynchronously by W_rst
         always_ff @(posedge W_clk or posedge W_rst) begin
            if (W_rst) begin
               out_reg <= '0;
               ovf_reg <= 1'b0;
            end else begin
               out_reg <= res_comb;
               ovf_reg <= ovf_comb;
            end
         end

         assign OUT = out_reg;
         assign OVF = ovf_reg;
      end else begin : g_comb
         // Purely combinational build: clock and reset are not used
         logic unused_clk_rst;
         assign unused_clk_rst = W_clk ^ W_rst;

         assign OUT = res_comb;
         assign OVF = ovf_comb;
      end
   endgenerate

endmodule : u_add_1

// File: tb/tb_u_add_1.sv
// Scoreboard bench for u_add_1 (WL=8): registered wrap, registered
// saturate and combinational wrap instances driven from one operand.
module tb_u_add_1;

   typedef struct packed {
      logic [7:0] out;
      logic       ovf;
   } exp_t;

   logic              W_clk;
   logic              W_rst;
   logic signed [7:0] dut_in;

   logic signed [7:0] out_wrap, out_sat, out_comb;
   logic              ovf_wrap, ovf_sat, ovf_comb;

   exp_t q_wrap[$];
   exp_t q_sat[$];
   exp_t q_comb[$];

   int n_vectors = 0;
   int n_checks  = 0;
   int n_errs    = 0;
   int ovf_pulses_wrap = 0;
   int ovf_pulses_comb = 0;

   u_add_1 #(.WL(8), .SAT(0), .LAT(1)) dut_wrap (
      .W_clk (W_clk), .W_rst (W_rst), .IN (dut_in), .OUT (out_wrap), .OVF (ovf_wrap)
   );

   u_add_1 #(.WL(8), .SAT(1), .LAT(1)) dut_sat (
      .W_clk (W_clk), .W_rst (W_rst), .IN (dut_in), .OUT (out_sat), .OVF (ovf_sat)
   );

   u_add_1 #(.WL(8), .SAT(0), .LAT(0)) dut_comb (
      .W_clk (W_clk), .W_rst (W_rst), .IN (dut_in), .OUT (out_comb), .OVF (ovf_comb)
   );

   initial W_clk = 1'b0;
   always #5 W_clk = ~W_clk;

   // Reference: signed increment, saturating or wrapping at +127
   function automatic exp_t model(input logic [7:0] v, input bit sat);
      exp_t e;
      int   s;
      s = int'($signed(v)) + 1;
      if (s > 127) s = sat ? 127 : -128;
      e.out = s[7:0];
      e.ovf = (v == 8'd127);
      return e;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // One stimulus cycle: drive at the falling edge, queue the expectations
   task automatic apply(input logic [7:0] v, input logic rst);
      exp_t e_wrap, e_sat, e_comb;
      @(negedge W_clk);
      dut_in = v;
      W_rst  = rst;
      n_vectors++;
      e_comb = model(v, 1'b0);
      e_wrap = rst ? '0 : e_comb;
      e_sat  = rst ? '0 : model(v, 1'b1);
      q_wrap.push_back(e_wrap);
      q_sat.push_back(e_sat);
      q_comb.push_back(e_comb);
      $display("vec %0d: IN=%0d rst=%0b exp wrap=%0d sat=%0d comb=%0d ovf=%0b",
               n_vectors, $signed(v), rst, $signed(e_wrap.out), $signed(e_sat.out),
               $signed(e_comb.out), e_comb.ovf);
      if (rst) begin
         // Reset must clear registered outputs without waiting for an edge
         #1;
         check("async_rst_out_wrap", int'(out_wrap), 0);
         check("async_rst_ovf_wrap", int'(ovf_wrap), 0);
         check("async_rst_out_sat",  int'(out_sat),  0);
      end
   endtask

   // Monitor: every result is valid each cycle; compare just after the edge
   always @(posedge W_clk) begin
      exp_t e;
      #1;
      if (q_wrap.size() > 0) begin
         e = q_wrap.pop_front();
         check("out_wrap", int'(out_wrap), int'($signed(e.out)));
         check("ovf_wrap", int'(ovf_wrap), int'(e.ovf));
         if (ovf_wrap) ovf_pulses_wrap++;
      end
      if (q_sat.size() > 0) begin
         e = q_sat.pop_front();
         check("out_sat", int'(out_sat), int'($signed(e.out)));
         check("ovf_sat", int'(ovf_sat), int'(e.ovf));
      end
      if (q_comb.size() > 0) begin
         e = q_comb.pop_front();
         check("out_comb", int'(out_comb), int'($signed(e.out)));
         check("ovf_comb", int'(ovf_comb), int'(e.ovf));
         if (ovf_comb) ovf_pulses_comb++;
      end
   end

   initial begin
      int base_wrap, base_comb;
      logic [7:0] v;

      // Reset held from time zero, checked before the first clock edge
      W_rst  = 1'b1;
      dut_in = 8'sd37;
      #2;
      check("rst_out_wrap", int'(out_wrap), 0);
      check("rst_ovf_wrap", int'(ovf_wrap), 0);
      check("rst_out_sat",  int'(out_sat),  0);
      check("rst_ovf_sat",  int'(ovf_sat),  0);
      check("rst_comb_follows", int'(out_comb), 38);

      // Directed corner vectors
      apply(8'd5,   1'b0);   // 6
      apply(8'd127, 1'b0);   // wrap -128 / sat 127, OVF
      apply(8'hFF,  1'b0);   // -1 -> 0
      apply(8'd126, 1'b0);   // 127, no OVF
      apply(8'h80,  1'b0);   // -128 -> -127
      apply(8'd0,   1'b0);   // 1

      // Full 256-code sweep; OVF must pulse exactly once
      @(posedge W_clk); #2;
      base_wrap = ovf_pulses_wrap;
      base_comb = ovf_pulses_comb;
      for (int i = 0; i < 256; i++) begin
         v = 8'(i);
         apply(v, 1'b0);
      end
      @(posedge W_clk); #2;
      check("sweep_ovf_pulses_wrap", ovf_pulses_wrap - base_wrap, 1);
      check("sweep_ovf_pulses_comb", ovf_pulses_comb - base_comb, 1);

      // Ramp with a two-cycle reset in the middle
      for (int i = 0; i < 16; i++) begin
         v = 8'(100 + i);
         apply(v, (i == 6) || (i == 7));
      end

      @(posedge W_clk); #2;
      check("queues_drained", q_wrap.size() + q_sat.size() + q_comb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errs);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule : tb_u_add_1
